// File: rtl/mem_stage_pkg.sv
// Shared pipeline types for the execute -> memory -> writeback boundary.
package mem_stage_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        RESP
    } mem_state_t;

    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] write_reg;
    } ex_mem_ctrl_t;

    // A read with the write bit also set behaves as a store.
    function automatic logic is_load(ex_mem_ctrl_t c);
        return c.mem_read & ~c.mem_write;
    endfunction

endpackage

// File: rtl/mem_stage_timeout_counter.sv
// Cycle counter for an outstanding memory request; tc flags the last allowed cycle.
module mem_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en)    cnt <= cnt + 8'd1;
    end

    // High during the LIMIT-th waiting cycle, so a missing ack there aborts.
    assign tc = (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: lw/sw over a req/ack bus, branch resolution, writeback forwarding.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int          ADDR_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_W-1:0]     alu_result,
    input  logic [WORD_W-1:0]     store_data,
    input  logic                  zero,
    input  logic [ADDR_W-1:0]     branch_target,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  branch,
    input  logic                  reg_write,
    input  logic                  mem_to_reg,
    input  logic [REG_ADDR_W-1:0] write_reg,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [WORD_W-1:0]     dmem_wdata,
    input  logic [WORD_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [WORD_W-1:0]     wb_data,
    output logic                  pc_src,
    output logic [ADDR_W-1:0]     pc_target,
    output logic                  align_err,
    output logic                  bus_err
);

    mem_state_t   state_q, state_d;
    ex_mem_ctrl_t ctrl;
    logic         accept, is_mem, aligned, start_mem, tc;
    logic         load_wb_q, load_data_q;

    assign ctrl = '{mem_read: mem_read, mem_write: mem_write, branch: branch,
                    reg_write: reg_write, mem_to_reg: mem_to_reg, write_reg: write_reg};

    assign in_ready  = rst_n & (state_q == IDLE);
    assign accept    = in_valid & in_ready;
    assign is_mem    = ctrl.mem_read | ctrl.mem_write;
    assign aligned   = (alu_result[1:0] == 2'b00);
    assign start_mem = accept & is_mem & aligned;

    mem_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_mem),
        .en    ((state_q == MEM_WAIT) & ~dmem_ack),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_mem)      state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ack || tc) state_d = RESP;
            RESP:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg       <= '0;
            wb_data      <= '0;
            pc_src       <= 1'b0;
            pc_target    <= '0;
            align_err    <= 1'b0;
            bus_err      <= 1'b0;
            load_wb_q    <= 1'b0;
            load_data_q  <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            pc_src    <= 1'b0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            if (accept) begin
                wb_reg      <= ctrl.write_reg;
                load_wb_q   <= is_load(ctrl) & ctrl.reg_write;
                load_data_q <= is_load(ctrl) & ctrl.mem_to_reg;
                if (is_mem && aligned) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= ctrl.mem_write;
                    dmem_addr  <= alu_result;
                    dmem_wdata <= store_data;
                end else begin
                    // Plain ALU op, or a misaligned access dropped without touching memory.
                    wb_valid     <= 1'b1;
                    wb_data      <= WORD_W'(alu_result);
                    wb_reg_write <= ctrl.reg_write & ~is_mem;
                    pc_src       <= ctrl.branch & zero & ~is_mem;
                    pc_target    <= branch_target;
                    align_err    <= is_mem;
                end
            end
            if (state_q == MEM_WAIT) begin
                if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    wb_data  <= load_data_q ? dmem_rdata : WORD_W'(dmem_addr);
                end else if (tc) begin
                    dmem_req <= 1'b0;
                    bus_err  <= 1'b1;
                    wb_data  <= WORD_W'(dmem_addr);
                end
            end
            if (state_q == RESP) begin
                // bus_err is high only in the RESP cycle following an abort.
                wb_valid     <= 1'b1;
                wb_reg_write <= load_wb_q & ~bus_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage with a scoreboarded memory model.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        zero = 1'b0;
    logic [31:0] branch_target = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        branch = 1'b0;
    logic        reg_write = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic [4:0]  write_reg = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        align_err, bus_err;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .zero(zero),
        .branch_target(branch_target), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .write_reg(write_reg), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_reg(wb_reg), .wb_data(wb_data), .pc_src(pc_src), .pc_target(pc_target),
        .align_err(align_err), .bus_err(bus_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Backing store contents for never-written words.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory responder: acks after ack_delay waiting cycles, or never when ack_en=0.
    logic [31:0] bus_mem [int unsigned];
    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    int          wait_cnt = 0;

    always @(negedge clk) begin
        if (dmem_req) begin
            if (ack_en && wait_cnt == ack_delay) begin
                dmem_ack = 1'b1;
                if (dmem_we) bus_mem[dmem_addr] = dmem_wdata;
                dmem_rdata = bus_mem.exists(dmem_addr) ? bus_mem[dmem_addr] : init_word(dmem_addr);
            end else begin
                dmem_ack = 1'b0;
                dmem_rdata = $urandom;
            end
            wait_cnt++;
        end else begin
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            wait_cnt = 0;
        end
    end

    // Reference view of architectural memory, updated only by committed stores.
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic run_op(input bit mr, input bit mw, input bit br, input bit rw,
                          input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] sd,
                          input bit z, input logic [31:0] tgt, input int dly, input bit en);
        bit is_mem, load, taken, timeout;
        int req_cycles, exp_req;
        is_mem = mr | mw;
        load   = mr & ~mw;
        taken  = !is_mem && br && z;
        ack_delay = dly;
        ack_en    = en;
        @(negedge clk);
        chk("wb_pulse_end", 32'(wb_valid), 32'd0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; mem_read = mr; mem_write = mw; branch = br; reg_write = rw;
        mem_to_reg = mr; write_reg = wr; alu_result = alu; store_data = sd;
        zero = z; branch_target = tgt;
        @(negedge clk);
        in_valid = 1'b0; alu_result = $urandom; store_data = $urandom;
        branch_target = $urandom; write_reg = 5'($urandom);
        if (!is_mem || alu[1:0] != 2'b00) begin
            chk("wb_valid_1cyc", 32'(wb_valid), 32'd1);
            chk("wb_data_alu", wb_data, alu);
            chk("wb_reg", 32'(wb_reg), 32'(wr));
            chk("wb_reg_write", 32'(wb_reg_write), 32'(!is_mem && rw));
            chk("pc_src", 32'(pc_src), 32'(taken));
            if (taken) chk("pc_target", pc_target, tgt);
            chk("align_err", 32'(align_err), 32'(is_mem));
            chk("no_req", 32'(dmem_req), 32'd0);
        end else begin
            chk("wb_valid_early", 32'(wb_valid), 32'd0);
            chk("dmem_req", 32'(dmem_req), 32'd1);
            chk("dmem_we", 32'(dmem_we), 32'(mw));
            chk("dmem_addr", dmem_addr, alu);
            if (mw) chk("dmem_wdata", dmem_wdata, sd);
            req_cycles = 0;
            while (dmem_req && req_cycles < 20) begin
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                req_cycles++;
                @(negedge clk);
            end
            timeout = !(en && dly < TO);
            exp_req = timeout ? TO : dly + 1;
            chk("req_cycles", 32'(req_cycles), 32'(exp_req));
            chk("bus_err", 32'(bus_err), 32'(timeout));
            chk("wb_valid_resp", 32'(wb_valid), 32'd0);
            @(negedge clk);
            chk("wb_valid_mem", 32'(wb_valid), 32'd1);
            chk("wb_reg_mem", 32'(wb_reg), 32'(wr));
            chk("wb_reg_write_mem", 32'(wb_reg_write), 32'(load && rw && !timeout));
            chk("pc_src_mem", 32'(pc_src), 32'd0);
            chk("bus_err_pulse", 32'(bus_err), 32'd0);
            if (!timeout) begin
                if (load) chk("wb_data_load", wb_data, ref_read(alu));
                else      chk("wb_data_store", wb_data, alu);
                if (mw) ref_mem[alu] = sd;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int kind;
        bus_mem[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_pc", {pc_target[30:0], pc_src}, 32'd0);
        chk("rst_errs", 32'({align_err, bus_err, wb_reg_write}), 32'd0);
        rst_n = 1'b1;

        run_op(0, 0, 0, 1, 5'd5, 32'h10, 32'h0, 0, 32'h0, 0, 1);          // add
        run_op(1, 0, 0, 1, 5'd8, 32'h100, 32'h0, 0, 32'h0, 2, 1);         // lw, ack after 2
        run_op(0, 1, 0, 0, 5'd0, 32'h204, 32'h12345678, 0, 32'h0, 0, 1);  // sw, immediate ack
        run_op(1, 0, 0, 1, 5'd9, 32'h204, 32'h0, 0, 32'h0, 1, 1);         // read back store
        run_op(0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 1, 32'h40, 0, 1);          // beq taken
        run_op(0, 0, 1, 0, 5'd0, 32'h4, 32'h0, 0, 32'h40, 0, 1);          // beq not taken
        run_op(1, 0, 0, 1, 5'd3, 32'h102, 32'h0, 0, 32'h0, 0, 1);         // misaligned lw
        run_op(1, 0, 0, 1, 5'd4, 32'h108, 32'h0, 0, 32'h0, 0, 0);         // timeout
        run_op(1, 0, 0, 1, 5'd6, 32'h10C, 32'h0, 0, 32'h0, TO - 1, 1);    // ack on last cycle
        run_op(1, 1, 0, 1, 5'd7, 32'h110, 32'hCAFEF00D, 0, 32'h0, 0, 1);  // rd+wr = store
        run_op(0, 1, 1, 0, 5'd0, 32'h114, 32'h55AA55AA, 1, 32'h80, 0, 1); // branch on mem op

        // Reset while a request is outstanding.
        ack_en = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; alu_result = 32'h118;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_req_up", 32'(dmem_req), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_req_drop", 32'(dmem_req), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_idle", 32'(in_ready), 32'd1);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 5);
            a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
            case (kind)
                0: run_op(0, 0, 0, 1, 5'($urandom), $urandom, 0, 0, 0, 0, 1);
                1: run_op(0, 0, 1, 0, 5'($urandom), $urandom, 0, 1'($urandom), $urandom, 0, 1);
                2, 3: run_op(1, 0, 0, 1, 5'($urandom), a, 0, 0, 0,
                             $urandom_range(0, 5), $urandom_range(0, 9) != 0);
                4: run_op(0, 1, 0, 0, 5'($urandom), a, $urandom, 0, 0,
                          $urandom_range(0, 5), $urandom_range(0, 9) != 0);
                default: run_op(1, 1, 1'($urandom), 1, 5'($urandom), a, $urandom, 1, 0,
                                $urandom_range(0, 5), 1);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
